// File: rtl/gat_bram_loader_pkg.sv
`default_nettype none
// ============================================================================
// gat_bram_loader_pkg : shared target encodings, FSM states, default widths
// Rev 1.0
// ============================================================================
package gat_bram_loader_pkg;

    localparam int c_top_width          = 32;
    localparam int c_h_data_addr_w      = 18;
    localparam int c_node_info_addr_w   = 14;
    localparam int c_weight_addr_w      = 15;
    localparam int c_subgraph_idx_addr_w = 14;

    typedef enum logic [1:0] {
        c_tgt_h_data    = 2'd0,
        c_tgt_node_info = 2'd1,
        c_tgt_wgt       = 2'd2,
        c_tgt_subgraph  = 2'd3
    } gat_target_e;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_stream = 2'd1;
    localparam logic [1:0] c_st_finish = 2'd2;

    function automatic logic [3:0] target_onehot(input gat_target_e tgt);
        return 4'b0001 << tgt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gat_bram_wr_port.sv
`default_nettype none
// ============================================================================
// gat_bram_wr_port : registered single-word BRAM write port (byte address)
// Rev 1.0
// ============================================================================
module gat_bram_wr_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] din,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W+1:0] addra
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din   <= '0;
            ena   <= 1'b0;
            wea   <= 1'b0;
            addra <= '0;
        end else begin
            ena <= wr_en;
            wea <= wr_en;
            // Address and data hold their last value between writes.
            if (wr_en) begin
                din   <= wr_data;
                addra <= {wr_addr, 2'b00};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gat_bram_loader.sv
`default_nettype none
// ============================================================================
// gat_bram_loader : streams host words into one of four GAT BRAMs
// Rev 1.0
// ============================================================================
module gat_bram_loader
    import gat_bram_loader_pkg::*;
#(
    parameter int TOP_WIDTH           = c_top_width,
    parameter int H_DATA_ADDR_W       = c_h_data_addr_w,
    parameter int NODE_INFO_ADDR_W    = c_node_info_addr_w,
    parameter int WEIGHT_ADDR_W       = c_weight_addr_w,
    parameter int SUBGRAPH_IDX_ADDR_W = c_subgraph_idx_addr_w,
    parameter int CNT_W               = H_DATA_ADDR_W + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_start,
    input  logic [1:0]                     cfg_target,
    input  logic [CNT_W-1:0]               cfg_num_words,
    input  logic                           cfg_clear,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [TOP_WIDTH-1:0]           s_data,
    input  logic                           s_last,
    output logic [TOP_WIDTH-1:0]           h_data_bram_din,
    output logic                           h_data_bram_ena,
    output logic                           h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]       h_data_bram_addra,
    output logic [TOP_WIDTH-1:0]           h_node_info_bram_din,
    output logic                           h_node_info_bram_ena,
    output logic                           h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0]    h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0]           wgt_bram_din,
    output logic                           wgt_bram_ena,
    output logic                           wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]       wgt_bram_addra,
    output logic [TOP_WIDTH-1:0]           subgraph_bram_din,
    output logic                           subgraph_bram_ena,
    output logic                           subgraph_bram_wea,
    output logic [SUBGRAPH_IDX_ADDR_W+1:0] subgraph_bram_addra,
    output logic                           h_data_bram_load_done,
    output logic                           h_node_info_bram_load_done,
    output logic                           wgt_bram_load_done,
    output logic                           subgraph_load_done,
    output logic                           busy,
    output logic                           err
);

    logic [1:0]       r_state;
    gat_target_e      r_target;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_index;
    logic [3:0]       r_done;
    logic             r_err;

    logic             w_hs;
    logic             w_last_word;
    logic             w_err_set;
    logic [3:0]       w_wr_en;
    logic [3:0]       w_done_set;

    assign w_hs        = s_valid && (r_state == c_st_stream);
    assign w_last_word = (r_index == (r_count - 1'b1));
    // Framing error: count exhausted without s_last, or s_last before the count.
    assign w_err_set   = w_hs && (w_last_word != s_last);
    assign w_wr_en     = w_hs ? target_onehot(r_target) : 4'b0000;
    assign w_done_set  = (r_state == c_st_finish) ? target_onehot(r_target) : 4'b0000;

    assign s_ready = (r_state == c_st_stream);
    assign busy    = (r_state != c_st_idle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_target <= c_tgt_h_data;
            r_count  <= '0;
            r_index  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cfg_start) begin
                        r_target <= gat_target_e'(cfg_target);
                        r_count  <= cfg_num_words;
                        r_index  <= '0;
                        r_state  <= (cfg_num_words != '0) ? c_st_stream : c_st_finish;
                    end
                end
                c_st_stream: begin
                    if (w_hs) begin
                        r_index <= r_index + 1'b1;
                        if (w_last_word || s_last) begin
                            r_state <= c_st_finish;
                        end
                    end
                end
                c_st_finish: r_state <= c_st_idle;
                default:     r_state <= c_st_idle;
            endcase
        end
    end

    // A set in the same cycle as cfg_clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 4'b0000;
            r_err  <= 1'b0;
        end else begin
            r_done <= (r_done & ~{4{cfg_clear}}) | w_done_set;
            r_err  <= (r_err & ~cfg_clear) | w_err_set;
        end
    end

    assign h_data_bram_load_done      = r_done[c_tgt_h_data];
    assign h_node_info_bram_load_done = r_done[c_tgt_node_info];
    assign wgt_bram_load_done         = r_done[c_tgt_wgt];
    assign subgraph_load_done         = r_done[c_tgt_subgraph];
    assign err                        = r_err;

    gat_bram_wr_port #(.DATA_W(TOP_WIDTH), .ADDR_W(H_DATA_ADDR_W)) u_h_data_port (
        .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en[c_tgt_h_data]), .wr_data(s_data),
        .wr_addr(r_index[H_DATA_ADDR_W-1:0]), .din(h_data_bram_din),
        .ena(h_data_bram_ena), .wea(h_data_bram_wea), .addra(h_data_bram_addra)
    );

    gat_bram_wr_port #(.DATA_W(TOP_WIDTH), .ADDR_W(NODE_INFO_ADDR_W)) u_node_info_port (
        .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en[c_tgt_node_info]), .wr_data(s_data),
        .wr_addr(r_index[NODE_INFO_ADDR_W-1:0]), .din(h_node_info_bram_din),
        .ena(h_node_info_bram_ena), .wea(h_node_info_bram_wea), .addra(h_node_info_bram_addra)
    );

    gat_bram_wr_port #(.DATA_W(TOP_WIDTH), .ADDR_W(WEIGHT_ADDR_W)) u_wgt_port (
        .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en[c_tgt_wgt]), .wr_data(s_data),
        .wr_addr(r_index[WEIGHT_ADDR_W-1:0]), .din(wgt_bram_din),
        .ena(wgt_bram_ena), .wea(wgt_bram_wea), .addra(wgt_bram_addra)
    );

    gat_bram_wr_port #(.DATA_W(TOP_WIDTH), .ADDR_W(SUBGRAPH_IDX_ADDR_W)) u_subgraph_port (
        .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en[c_tgt_subgraph]), .wr_data(s_data),
        .wr_addr(r_index[SUBGRAPH_IDX_ADDR_W-1:0]), .din(subgraph_bram_din),
        .ena(subgraph_bram_ena), .wea(subgraph_bram_wea), .addra(subgraph_bram_addra)
    );

endmodule
`default_nettype wire

// File: tb/tb_gat_bram_loader.sv
`default_nettype none
// ============================================================================
// tb_gat_bram_loader : table-driven loads with a write scoreboard
// Rev 1.0
// ============================================================================
module tb_gat_bram_loader;

    localparam int c_tw = 32;
    localparam int c_cw = 19;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_start, cfg_clear;
    logic [1:0]      cfg_target;
    logic [c_cw-1:0] cfg_num_words;
    logic            s_valid, s_ready, s_last;
    logic [c_tw-1:0] s_data;
    logic [c_tw-1:0] h_data_bram_din, h_node_info_bram_din, wgt_bram_din, subgraph_bram_din;
    logic            h_data_bram_ena, h_node_info_bram_ena, wgt_bram_ena, subgraph_bram_ena;
    logic            h_data_bram_wea, h_node_info_bram_wea, wgt_bram_wea, subgraph_bram_wea;
    logic [19:0]     h_data_bram_addra;
    logic [15:0]     h_node_info_bram_addra;
    logic [16:0]     wgt_bram_addra;
    logic [15:0]     subgraph_bram_addra;
    logic            h_data_bram_load_done, h_node_info_bram_load_done;
    logic            wgt_bram_load_done, subgraph_load_done, busy, err;
    logic [3:0]      done_vec;

    assign done_vec = {subgraph_load_done, wgt_bram_load_done,
                       h_node_info_bram_load_done, h_data_bram_load_done};

    always #5 clk = ~clk;

    gat_bram_loader dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_target(cfg_target),
        .cfg_num_words(cfg_num_words), .cfg_clear(cfg_clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .h_data_bram_din(h_data_bram_din), .h_data_bram_ena(h_data_bram_ena),
        .h_data_bram_wea(h_data_bram_wea), .h_data_bram_addra(h_data_bram_addra),
        .h_node_info_bram_din(h_node_info_bram_din), .h_node_info_bram_ena(h_node_info_bram_ena),
        .h_node_info_bram_wea(h_node_info_bram_wea), .h_node_info_bram_addra(h_node_info_bram_addra),
        .wgt_bram_din(wgt_bram_din), .wgt_bram_ena(wgt_bram_ena),
        .wgt_bram_wea(wgt_bram_wea), .wgt_bram_addra(wgt_bram_addra),
        .subgraph_bram_din(subgraph_bram_din), .subgraph_bram_ena(subgraph_bram_ena),
        .subgraph_bram_wea(subgraph_bram_wea), .subgraph_bram_addra(subgraph_bram_addra),
        .h_data_bram_load_done(h_data_bram_load_done),
        .h_node_info_bram_load_done(h_node_info_bram_load_done),
        .wgt_bram_load_done(wgt_bram_load_done), .subgraph_load_done(subgraph_load_done),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic [1:0]  tgt;
        logic [19:0] addr;
        logic [31:0] data;
        logic        wea;
    } wr_t;

    typedef struct {
        logic [1:0]  tgt;
        int          count;
        int          nsend;
        int          last_idx;
        bit          gap;
        logic        exp_err;
        logic [31:0] base;
    } vec_t;

    wr_t        exp_q[$];
    wr_t        got_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_done;

    // Every enabled write port produces one observed record per cycle.
    always @(negedge clk) begin
        if (h_data_bram_ena)
            got_q.push_back('{2'd0, 20'(h_data_bram_addra), h_data_bram_din, h_data_bram_wea});
        if (h_node_info_bram_ena)
            got_q.push_back('{2'd1, 20'(h_node_info_bram_addra), h_node_info_bram_din, h_node_info_bram_wea});
        if (wgt_bram_ena)
            got_q.push_back('{2'd2, 20'(wgt_bram_addra), wgt_bram_din, wgt_bram_wea});
        if (subgraph_bram_ena)
            got_q.push_back('{2'd3, 20'(subgraph_bram_addra), subgraph_bram_din, subgraph_bram_wea});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({busy, s_ready, err, done_vec}), 64'd0);
        chk({tag, "_ena_wea"}, 64'({h_data_bram_ena, h_node_info_bram_ena, wgt_bram_ena, subgraph_bram_ena,
                                    h_data_bram_wea, h_node_info_bram_wea, wgt_bram_wea, subgraph_bram_wea}), 64'd0);
        chk({tag, "_addr_a"}, 64'({h_data_bram_addra, h_node_info_bram_addra}), 64'd0);
        chk({tag, "_addr_b"}, 64'({wgt_bram_addra, subgraph_bram_addra}), 64'd0);
        chk({tag, "_din_a"}, {h_data_bram_din, h_node_info_bram_din}, 64'd0);
        chk({tag, "_din_b"}, {wgt_bram_din, subgraph_bram_din}, 64'd0);
    endtask

    task automatic compare_sb();
        wr_t e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL missing_write actual=none required=tgt%0d addr=%h data=%h", e.tgt, e.addr, e.data);
            end else begin
                g = got_q.pop_front();
                chk("write", 64'({g.tgt, g.addr, g.data, g.wea}), 64'({e.tgt, e.addr, e.data, 1'b1}));
            end
        end
        chk("extra_writes", 64'(got_q.size()), 64'd0);
        got_q.delete();
    endtask

    task automatic start_load(input logic [1:0] t, input int n);
        @(posedge clk); #1;
        cfg_start     = 1'b1;
        cfg_target    = t;
        cfg_num_words = c_cw'(n);
        @(posedge clk); #1;
        cfg_start     = 1'b0;
    endtask

    task automatic send_word(input logic [1:0] t, input int idx, input logic [31:0] d, input logic last);
        logic ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("handshake_ready", 64'(ok), 64'd1);
        if (ok) begin
            exp_q.push_back('{t, 20'(idx * 4), d, 1'b1});
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic finish_load(input logic [1:0] t, input logic exp_err_v);
        @(negedge clk);
        chk("done_not_early", 64'(done_vec[t]), 64'd0);
        @(negedge clk);
        exp_done[t] = 1'b1;
        chk("done_flags", 64'(done_vec), 64'(exp_done));
        chk("err_flag", 64'(err), 64'(exp_err_v));
        chk("busy_after", 64'(busy), 64'd0);
        compare_sb();
        @(posedge clk); #1;
        cfg_clear = 1'b1;
        @(posedge clk); #1;
        cfg_clear = 1'b0;
        exp_done  = 4'b0000;
        @(negedge clk);
        chk("cleared", 64'({done_vec, err}), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 4, 4,  3, 1'b0, 1'b0, 32'h11};
        vecs[1] = '{2'd2, 3, 3,  2, 1'b1, 1'b0, 32'hA0};
        vecs[2] = '{2'd1, 5, 2,  1, 1'b0, 1'b1, 32'h50};
        vecs[3] = '{2'd3, 0, 0, -1, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{2'd1, 2, 2, -1, 1'b0, 1'b1, 32'hC0};
        vecs[5] = '{2'd3, 3, 3,  2, 1'b1, 1'b0, 32'hE0};

        exp_done      = 4'b0000;
        rst_n         = 1'b0;
        cfg_start     = 1'b0;
        cfg_clear     = 1'b0;
        cfg_target    = 2'd0;
        cfg_num_words = '0;
        s_valid       = 1'b0;
        s_last        = 1'b0;
        s_data        = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            start_load(vecs[v].tgt, vecs[v].count);
            for (int i = 0; i < vecs[v].nsend; i++) begin
                if (vecs[v].gap && i > 0) begin @(posedge clk); #1; end
                send_word(vecs[v].tgt, i, vecs[v].base + 32'(i), (i == vecs[v].last_idx));
            end
            finish_load(vecs[v].tgt, vecs[v].exp_err);
        end

        // cfg_start during STREAM must not disturb the active load.
        start_load(2'd2, 3);
        send_word(2'd2, 0, 32'h300, 1'b0);
        cfg_start     = 1'b1;
        cfg_target    = 2'd0;
        cfg_num_words = c_cw'(1);
        @(posedge clk); #1;
        cfg_start     = 1'b0;
        send_word(2'd2, 1, 32'h301, 1'b0);
        send_word(2'd2, 2, 32'h302, 1'b1);
        finish_load(2'd2, 1'b0);

        // Asynchronous reset in the middle of a stream, with a done flag already set.
        start_load(2'd3, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_done", 64'(subgraph_load_done), 64'd1);
        start_load(2'd0, 6);
        send_word(2'd0, 0, 32'h400, 1'b0);
        send_word(2'd0, 1, 32'h401, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'h402;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_flags", 64'({done_vec, err, busy}), 64'd0);
        compare_sb();

        start_load(2'd0, 2);
        send_word(2'd0, 0, 32'h500, 1'b0);
        send_word(2'd0, 1, 32'h501, 1'b1);
        finish_load(2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
